// File: rtl/instruction_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: RV32I constants, FSM
// state encoding, the buffered fetch entry layout and a PC alignment helper.
package instruction_fetch_unit_pkg;

    // Canonical RV32I no-op (addi x0, x0, 0), shown to decode when idle.
    localparam logic [31:0] RV32I_NOP = 32'h0000_0013;

    // Default first fetch address after reset.
    localparam logic [31:0] IFU_DEFAULT_RESET_PC = 32'h0000_0000;

    // Fetch control states: one idle cycle after reset, then run forever.
    typedef enum logic {
        S_BOOT = 1'b0,
        S_RUN  = 1'b1
    } ifu_state_e;

    // One buffered instruction together with the address it was fetched from.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    // Force a byte address onto a word boundary.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_instr_fifo.sv
// Synchronous instruction buffer holding {pc, instr} entries between the
// memory response path and the decoder. Registered output, no bypass:
// a word pushed on one edge is visible at the head from the next cycle.
module if_instr_fifo
    import instruction_fetch_unit_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  fetch_entry_t             push_data,
    input  logic                     pop,
    input  logic                     flush,
    output fetch_entry_t             head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    fetch_entry_t    mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q,  count_d;
    logic            do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign count   = count_q;
    assign head    = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointer and occupancy update; flush discards every buffered entry.
    always_comb begin
        // NOTE: every signal gets a default before any branch, otherwise a path that skips the assignment infers a latch.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are only observed while count says they are valid.
    always_ff @(posedge clk) begin
        // NOTE: storage array is deliberately not reset; occupancy tracking makes stale contents harmless and keeps it RAM-mappable.
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Front-end fetch stage: owns the PC, issues in-order word fetches under a
// credit limit, buffers returned words with their PCs and hands them to the
// decoder over valid/ready. Redirects flush the buffer, mark every in-flight
// response stale and restart fetching at the target.
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = IFU_DEFAULT_RESET_PC,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instruction,
    output logic [31:0] id_pc
);

    localparam int            CW        = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW:0]   DEPTH_LIM = FIFO_DEPTH[CW:0];

    ifu_state_e      state_q, state_d;
    logic [31:0]     pc_q, pc_d;
    logic [31:0]     resp_pc_q, resp_pc_d;   // PC of the next non-stale response
    logic [CW-1:0]   outstanding_q, outstanding_d;
    logic [CW-1:0]   drop_cnt_q, drop_cnt_d;

    fetch_entry_t    fifo_head;
    fetch_entry_t    fifo_wdata;
    logic [CW-1:0]   fifo_count;
    logic            fifo_empty, fifo_full;
    logic            fifo_push, fifo_pop;
    logic            req_fire, drop_now, credit_ok;
    logic [CW:0]     in_flight;

    assign in_flight = {1'b0, outstanding_q} + {1'b0, fifo_count};
    assign credit_ok = (in_flight < DEPTH_LIM);
    assign req_fire  = imem_req_valid && imem_req_ready;
    assign drop_now  = imem_resp_valid && (drop_cnt_q != '0);

    // Responses arriving during a redirect are wrong-path and never buffered.
    assign fifo_push  = imem_resp_valid && (drop_cnt_q == '0) && !redirect_valid;
    assign fifo_wdata = '{pc: resp_pc_q, instr: imem_resp_data};
    assign fifo_pop   = id_valid && id_ready;

    assign imem_req_addr  = pc_q;
    assign id_valid       = !fifo_empty && !redirect_valid;
    assign id_instruction = fifo_empty ? RV32I_NOP : fifo_head.instr;
    assign id_pc          = fifo_empty ? RESET_PC  : fifo_head.pc;

    if_instr_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data (fifo_wdata),
        .pop       (fifo_pop),
        .flush     (redirect_valid),
        .head      (fifo_head),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    // FSM next state and request issue: one silent boot cycle, then issue while credits remain.
    always_comb begin
        state_d        = state_q;
        imem_req_valid = 1'b0;
        case (state_q)
            S_BOOT:  state_d = S_RUN;
            S_RUN:   imem_req_valid = credit_ok;
            default: state_d = S_BOOT;
        endcase
    end

    // PC, credit and stale-response bookkeeping; a redirect overrides the normal updates.
    always_comb begin
        pc_d          = pc_q;
        resp_pc_d     = resp_pc_q;
        drop_cnt_d    = drop_cnt_q;
        outstanding_d = outstanding_q + CW'(req_fire) - CW'(imem_resp_valid);

        if (req_fire)  pc_d       = pc_q + 32'd4;
        if (fifo_push) resp_pc_d  = resp_pc_q + 32'd4;
        if (drop_now)  drop_cnt_d = drop_cnt_q - CW'(1);

        if (redirect_valid) begin
            // Everything still in flight after this edge belongs to the old path.
            pc_d       = align_word(redirect_pc);
            resp_pc_d  = align_word(redirect_pc);
            drop_cnt_d = outstanding_d;
        end
    end

    // Top-level state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_BOOT;
            pc_q          <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    // The credit rule must make a push into a full buffer impossible.
    a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst_n)
        !(fifo_push && fifo_full && !fifo_pop));

    // In-flight requests never exceed the buffer depth.
    a_outstanding_bound: assert property (@(posedge clk) disable iff (!rst_n)
        outstanding_q <= CW'(FIFO_DEPTH));

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instruction;
    logic [31:0] id_pc;

    int errors = 0;
    int checks = 0;

    // Memory model state and delivery scoreboard.
    logic [31:0] mq   [$];
    logic [31:0] dpc  [$];
    logic [31:0] dins [$];
    int          accept_cnt = 0;
    bit          resp_hold  = 1'b0;

    instruction_fetch_unit dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .id_valid        (id_valid),
        .id_ready        (id_ready),
        .id_instruction  (id_instruction),
        .id_pc           (id_pc)
    );

    always #5 clk = ~clk;

    // Record accepted requests (pre-edge values).
    always @(posedge clk) begin
        if (rst_n && imem_req_valid && imem_req_ready) begin
            mq.push_back(imem_req_addr);
            accept_cnt++;
        end
    end

    // Return one response per cycle, one cycle after acceptance; data = ~address.
    always @(negedge clk) begin
        if (!rst_n) begin
            mq.delete();
            imem_resp_valid = 1'b0;
            imem_resp_data  = '0;
        end else if (!resp_hold && mq.size() > 0) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = ~mq.pop_front();
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = '0;
        end
    end

    // Capture every instruction handed to decode.
    always @(posedge clk) begin
        if (rst_n && id_valid && id_ready) begin
            dpc.push_back(id_pc);
            dins.push_back(id_instruction);
        end
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_req_ready = 1'b1;
        resp_hold      = 1'b0;
        repeat (2) @(negedge clk);
        dpc.delete();
        dins.delete();
        accept_cnt = 0;
        rst_n      = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " req_valid"}, {31'b0, imem_req_valid}, 32'd0);
        check({tag, " req_addr"},  imem_req_addr,           32'h0);
        check({tag, " id_valid"},  {31'b0, id_valid},       32'd0);
        check({tag, " id_instr"},  id_instruction,          NOP);
        check({tag, " id_pc"},     id_pc,                   32'h0);
    endtask

    task automatic wait_deliv(input string tag, input int n, input int budget);
        int k = 0;
        while (dpc.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check({tag, " delivered_enough"}, {31'b0, dpc.size() >= n}, 32'd1);
    endtask

    initial begin
        logic        prev_valid;
        logic        prev_ready;
        logic [31:0] prev_addr;

        rst_n           = 1'b0;
        imem_req_ready  = 1'b1;
        redirect_valid  = 1'b0;
        redirect_pc     = '0;
        id_ready        = 1'b1;

        // 1: outputs during reset
        #12;
        check_reset_outputs("reset");

        // 2: streaming, first id_valid three edges after reset release
        id_ready = 1'b1;
        do_reset();
        #1;
        check("boot no_req", {31'b0, imem_req_valid}, 32'd0);
        @(negedge clk);
        check("run req_valid", {31'b0, imem_req_valid}, 32'd1);
        check("run req_addr", imem_req_addr, 32'h0);
        @(negedge clk);
        check("stream id_valid_early", {31'b0, id_valid}, 32'd0);
        @(negedge clk);
        check("stream id_valid_first", {31'b0, id_valid}, 32'd1);
        check("stream id_pc0", id_pc, 32'h0);
        check("stream id_instr0", id_instruction, ~32'h0);
        for (int k = 1; k < 8; k++) begin
            @(negedge clk);
            check($sformatf("stream valid%0d", k), {31'b0, id_valid}, 32'd1);
            check($sformatf("stream pc%0d", k), id_pc, 32'(4 * k));
        end

        // 3: decoder stalled, credit limit holds issue at FIFO_DEPTH
        id_ready = 1'b0;
        do_reset();
        repeat (20) @(negedge clk);
        check("stall accepted", 32'(accept_cnt), 32'd4);
        check("stall req_valid", {31'b0, imem_req_valid}, 32'd0);
        check("stall head_pc", id_pc, 32'h0);
        id_ready = 1'b1;
        wait_deliv("stall", 6, 40);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("stall order pc%0d", i), dpc[i], 32'(4 * i));
            check($sformatf("stall order in%0d", i), dins[i], ~32'(4 * i));
        end

        // 4: random request back-pressure; address held, no PC skipped or repeated
        id_ready = 1'b1;
        do_reset();
        prev_valid = 1'b0;
        prev_ready = 1'b1;
        prev_addr  = '0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (prev_valid && !prev_ready) begin
                check("bp valid_held", {31'b0, imem_req_valid}, 32'd1);
                check("bp addr_held", imem_req_addr, prev_addr);
            end
            prev_valid     = imem_req_valid;
            prev_addr      = imem_req_addr;
            imem_req_ready = 1'($urandom_range(0, 1));
            prev_ready     = imem_req_ready;
        end
        imem_req_ready = 1'b1;
        wait_deliv("bp", 20, 60);
        for (int i = 0; i < 20; i++) begin
            check($sformatf("bp seq pc%0d", i), dpc[i], 32'(4 * i));
        end

        // 5: redirect with three requests outstanding
        id_ready = 1'b1;
        do_reset();
        resp_hold = 1'b1;
        repeat (4) @(negedge clk);
        check("redir3 outstanding", 32'(accept_cnt), 32'd3);
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0100;
        @(negedge clk);
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
        resp_hold      = 1'b0;
        check("redir3 new_addr", imem_req_addr, 32'h100);
        wait_deliv("redir3", 2, 40);
        check("redir3 pc0", dpc[0], 32'h100);
        check("redir3 pc1", dpc[1], 32'h104);
        check("redir3 in0", dins[0], ~32'h100);

        // 6: unaligned redirect coinciding with an accept and a response
        id_ready = 1'b1;
        do_reset();
        repeat (6) @(negedge clk);
        dpc.delete();
        dins.delete();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0203;
        #1;
        check("redir_same id_valid_masked", {31'b0, id_valid}, 32'd0);
        check("redir_same accept_cycle", {31'b0, imem_req_valid}, 32'd1);
        @(negedge clk);
        redirect_valid = 1'b0;
        check("redir_same aligned_addr", imem_req_addr, 32'h200);
        wait_deliv("redir_same", 2, 40);
        check("redir_same pc0", dpc[0], 32'h200);
        check("redir_same pc1", dpc[1], 32'h204);
        check("redir_same in1", dins[1], ~32'h204);

        // 7: reset asserted mid-stream, then refetch from RESET_PC
        id_ready = 1'b1;
        do_reset();
        repeat (6) @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        do_reset();
        wait_deliv("refetch", 2, 40);
        check("refetch pc0", dpc[0], 32'h0);
        check("refetch pc1", dpc[1], 32'h4);

        // 8: redirect while still in the boot cycle
        id_ready = 1'b1;
        do_reset();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0040;
        @(negedge clk);
        redirect_valid = 1'b0;
        check("boot_redir addr", imem_req_addr, 32'h40);
        wait_deliv("boot_redir", 2, 40);
        check("boot_redir pc0", dpc[0], 32'h40);
        check("boot_redir pc1", dpc[1], 32'h44);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
